// File: rtl/psum_rmw_accumulator.sv
// ----------------------------------------------------------------------------
// psum_rmw_accumulator
//
// Read-modify-write front end for one port of a dual-port RAM. It accepts a
// stream of (address, value) partial sums, issues the RAM read and, L cycles
// later (L = 1 + Pipelined), writes back the stored word plus the value.
// A same-address hazard inside the RAM read window is resolved by forwarding
// from a short history of the last L writes. A whole-memory clear sweep is
// also provided.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   in_valid_i/ready_o  psum handshake
//   in_addr_i           target address
//   in_data_i           signed value to accumulate
//   in_first_i          overwrite instead of accumulate
//   clr_all_i           single-cycle request to zero the whole memory
//   busy_o              clear pending (drain) or sweep running
//   clr_done_o          one-cycle pulse after the last clear write
//   ram_re_o            RAM read enable (combinational from the handshake)
//   ram_addr_r_o        RAM read address
//   ram_data_i          RAM read data, valid L cycles after ram_re_o
//   ram_we_o            RAM write enable
//   ram_addr_w_o        RAM write address
//   ram_data_o          RAM write data
// ----------------------------------------------------------------------------
module psum_rmw_accumulator #(
    parameter int AddrWidth = 16,
    parameter int DataWidth = 32,
    parameter int Pipelined = 0,
    parameter int Saturate  = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [AddrWidth-1:0]        in_addr_i,
    input  logic signed [DataWidth-1:0] in_data_i,
    input  logic                        in_first_i,
    input  logic                        clr_all_i,
    output logic                        busy_o,
    output logic                        clr_done_o,
    output logic                        ram_re_o,
    output logic [AddrWidth-1:0]        ram_addr_r_o,
    input  logic [DataWidth-1:0]        ram_data_i,
    output logic                        ram_we_o,
    output logic [AddrWidth-1:0]        ram_addr_w_o,
    output logic [DataWidth-1:0]        ram_data_o
);

    localparam int Lat = 1 + Pipelined;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    // One extra bit: the terminal count 2^AddrWidth marks the clr_done cycle.
    logic [AddrWidth:0]              r_clr_cnt;
    logic [AddrWidth:0]              w_clr_cnt_nxt;

    // Operand shift pipeline, index Lat-1 is the write stage.
    logic [Lat-1:0]                  r_pv;
    logic [Lat-1:0][AddrWidth-1:0]   r_pa;
    logic [Lat-1:0][DataWidth-1:0]   r_pd;
    logic [Lat-1:0]                  r_pf;

    // Write history, index 0 is the youngest entry.
    logic [Lat-1:0]                  r_hv;
    logic [Lat-1:0][AddrWidth-1:0]   r_ha;
    logic [Lat-1:0][DataWidth-1:0]   r_hd;

    logic                            w_acc;
    logic                            w_op_v;
    logic                            w_clr_wr;
    logic                            w_hit;
    logic [DataWidth-1:0]            w_fwd;
    logic signed [DataWidth-1:0]     w_base;
    logic signed [DataWidth-1:0]     w_addend;
    logic signed [DataWidth:0]       w_sum;
    logic [DataWidth-1:0]            w_result;

    // Reduce the DataWidth+1 sum to DataWidth: wrap or clamp to the signed range.
    function automatic logic [DataWidth-1:0] f_clamp(input logic signed [DataWidth:0] s);
        logic [DataWidth-1:0] res;
        res = s[DataWidth-1:0];
        if ((Saturate != 0) && (s[DataWidth] != s[DataWidth-1])) begin
            res = s[DataWidth] ? {1'b1, {(DataWidth-1){1'b0}}}
                               : {1'b0, {(DataWidth-1){1'b1}}};
        end
        return res;
    endfunction

    // Ready is masked during reset because the async reset leaves the FSM in IDLE.
    assign in_ready_o   = (r_state == S_IDLE) && !clr_all_i && !rst_i;
    assign w_acc        = in_valid_i && in_ready_o;
    assign ram_re_o     = w_acc;
    assign ram_addr_r_o = w_acc ? in_addr_i : '0;

    // FSM next state and clear-sweep outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        busy_o        = 1'b0;
        clr_done_o    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clr_all_i) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy_o = 1'b1;
                if (r_pv == '0) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            S_CLEAR: begin
                if (r_clr_cnt[AddrWidth]) begin
                    clr_done_o  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    busy_o        = 1'b1;
                    w_clr_cnt_nxt = r_clr_cnt + {{AddrWidth{1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Youngest matching history entry wins, so scan oldest to youngest.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        for (int i = Lat - 1; i >= 0; i--) begin
            if (r_hv[i] && (r_ha[i] == r_pa[Lat-1])) begin
                w_hit = 1'b1;
                w_fwd = r_hd[i];
            end
        end
    end

    // Write stage: base selection, add, wrap/saturate
    always_comb begin
        if (r_pf[Lat-1]) begin
            w_base = '0;
        end else if (w_hit) begin
            w_base = w_fwd;
        end else begin
            w_base = ram_data_i;
        end
        w_addend = r_pd[Lat-1];
        w_sum    = {w_base[DataWidth-1], w_base} + {w_addend[DataWidth-1], w_addend};
        w_result = f_clamp(w_sum);
    end

    // The pipeline is empty during the sweep, so the two write sources never collide.
    assign w_op_v   = r_pv[Lat-1];
    assign w_clr_wr = (r_state == S_CLEAR) && !r_clr_cnt[AddrWidth];

    always_comb begin
        ram_we_o     = w_op_v || w_clr_wr;
        ram_addr_w_o = '0;
        ram_data_o   = '0;
        if (w_clr_wr) begin
            ram_addr_w_o = r_clr_cnt[AddrWidth-1:0];
        end else if (w_op_v) begin
            ram_addr_w_o = r_pa[Lat-1];
            ram_data_o   = w_result;
        end
    end

    // Stage boundary: control state, valid tags of pipeline and history
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_clr_cnt <= '0;
            r_pv      <= '0;
            r_hv      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_pv[0]   <= w_acc;
            r_hv[0]   <= ram_we_o;
            for (int i = 1; i < Lat; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_hv[i] <= r_hv[i-1];
            end
        end
    end

    // Stage boundary: operand and history payloads, qualified by the tags above
    always_ff @(posedge clk_i) begin
        r_pa[0] <= in_addr_i;
        r_pd[0] <= in_data_i;
        r_pf[0] <= in_first_i;
        r_ha[0] <= ram_addr_w_o;
        r_hd[0] <= ram_data_o;
        for (int i = 1; i < Lat; i++) begin
            r_pa[i] <= r_pa[i-1];
            r_pd[i] <= r_pd[i-1];
            r_pf[i] <= r_pf[i-1];
            r_ha[i] <= r_ha[i-1];
            r_hd[i] <= r_hd[i-1];
        end
    end

endmodule

// File: tb/tb_psum_rmw_accumulator.sv
// ----------------------------------------------------------------------------
// tb_psum_rmw_accumulator
//
// Two instances share one stimulus stream: instance 0 is Pipelined=1 with
// saturation, instance 1 is Pipelined=0 with wrap-around. Each has its own
// behavioural RAM. Stimulus pushes expected writes into a queue computed from
// an ideal memory model; a negedge monitor pops and compares per instance.
// ----------------------------------------------------------------------------
module tb_psum_rmw_accumulator;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 16;
    localparam int NI = 2;

    typedef struct packed {
        logic                   is_done;
        logic [AW-1:0]          addr;
        logic [NI-1:0][DW-1:0]  val;
        int                     acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          in_first;
    logic          clr_all;

    logic          in_ready [NI];
    logic          busy     [NI];
    logic          clr_done [NI];
    logic          re       [NI];
    logic          we       [NI];
    logic [AW-1:0] addr_r   [NI];
    logic [AW-1:0] addr_w   [NI];
    logic [DW-1:0] rdata    [NI];
    logic [DW-1:0] wdata    [NI];

    exp_t expq[$];
    exp_t mon_e;
    int   model [NI][N];
    int   rdp   [NI];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   exp_acc;
    bit   chk_busy;
    bit   fin;
    bit   stim_tmo;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int PIPE = (gi == 0) ? 1 : 0;
        localparam int SATP = (gi == 0) ? 1 : 0;

        psum_rmw_accumulator #(
            .AddrWidth(AW), .DataWidth(DW), .Pipelined(PIPE), .Saturate(SATP)
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .in_valid_i   (in_valid),
            .in_ready_o   (in_ready[gi]),
            .in_addr_i    (in_addr),
            .in_data_i    (in_data),
            .in_first_i   (in_first),
            .clr_all_i    (clr_all),
            .busy_o       (busy[gi]),
            .clr_done_o   (clr_done[gi]),
            .ram_re_o     (re[gi]),
            .ram_addr_r_o (addr_r[gi]),
            .ram_data_i   (rdata[gi]),
            .ram_we_o     (we[gi]),
            .ram_addr_w_o (addr_w[gi]),
            .ram_data_o   (wdata[gi])
        );

        // Behavioural RAM: read returns contents before the same cycle's write.
        logic [DW-1:0] mem [N];
        logic [DW-1:0] rd_a = '0;
        logic [DW-1:0] rd_b = '0;
        initial for (int k = 0; k < N; k++) mem[k] = '0;
        always @(posedge clk) begin
            if (re[gi]) rd_a <= mem[addr_r[gi]];
            rd_b <= rd_a;
            if (we[gi]) mem[addr_w[gi]] <= wdata[gi];
        end
        assign rdata[gi] = (PIPE != 0) ? rd_b : rd_a;
    end

    // Reference accumulation on plain signed integers.
    function automatic int ref_acc(input int old, input int d, input bit first, input bit sat);
        int s;
        s = (first ? 0 : old) + d;
        if (sat) begin
            if (s > 127)  s = 127;
            if (s < -128) s = -128;
        end else begin
            s = s & 255;
            if (s > 127) s = s - 256;
        end
        return s;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs and record the expected consequences.
    task automatic set_in(input bit v, input int a, input int d, input bit f, input bit clr);
        exp_t e;
        in_valid = v;
        in_addr  = a[AW-1:0];
        in_data  = d[DW-1:0];
        in_first = f;
        clr_all  = clr;
        exp_acc  = v && !clr;
        if (clr) begin
            for (int k = 0; k < N; k++) begin
                e = '0;
                e.addr = k[AW-1:0];
                e.acc_cyc = -1;
                expq.push_back(e);
            end
            e = '0;
            e.is_done = 1'b1;
            e.acc_cyc = -1;
            expq.push_back(e);
            for (int i = 0; i < NI; i++)
                for (int k = 0; k < N; k++) model[i][k] = 0;
        end else if (v) begin
            e = '0;
            e.addr = a[AW-1:0];
            e.acc_cyc = cyc;
            for (int i = 0; i < NI; i++) begin
                int r;
                r = ref_acc(model[i][a], d, f, (i == 0));
                model[i][a] = r;
                e.val[i] = r[DW-1:0];
            end
            expq.push_back(e);
        end
    endtask

    task automatic report(input string nm, input int i, input int got, input int want);
        n_err++;
        $display("FAIL %s inst%0d: got %0d, want %0d (cycle %0d)", nm, i, got, want, cyc);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                n_vec++;
                if ({in_ready[i], busy[i], clr_done[i], re[i], we[i],
                     addr_r[i], addr_w[i], wdata[i]} != '0)
                    report("reset_outputs", i,
                           int'({in_ready[i], busy[i], clr_done[i], re[i], we[i],
                                 addr_r[i], addr_w[i], wdata[i]}), 0);
                rdp[i] = expq.size();
            end else begin
                n_vec++;
                if (re[i] !== exp_acc) report("read_enable", i, int'(re[i]), int'(exp_acc));
                if (in_valid) begin
                    n_vec++;
                    if (in_ready[i] !== exp_acc) report("in_ready", i, int'(in_ready[i]), int'(exp_acc));
                end
                if (re[i]) begin
                    n_vec++;
                    if (addr_r[i] !== in_addr) report("read_addr", i, int'(addr_r[i]), int'(in_addr));
                end
                if (busy[i]) begin
                    n_vec++;
                    if (in_ready[i] !== 1'b0) report("ready_while_busy", i, int'(in_ready[i]), 0);
                end
                if (chk_busy) begin
                    n_vec++;
                    if (busy[i] !== 1'b1) report("busy_after_clr", i, int'(busy[i]), 1);
                end
                if (we[i] || clr_done[i]) begin
                    n_vec++;
                    if (rdp[i] >= expq.size()) begin
                        report("unexpected_write", i, int'(addr_w[i]), -1);
                    end else begin
                        mon_e = expq[rdp[i]];
                        rdp[i]++;
                        if (mon_e.is_done) begin
                            if (!clr_done[i] || we[i])
                                report("clr_done", i, int'({clr_done[i], we[i]}), 2);
                        end else begin
                            if (clr_done[i] || !we[i])
                                report("write_enable", i, int'({clr_done[i], we[i]}), 1);
                            else if (addr_w[i] !== mon_e.addr)
                                report("write_addr", i, int'(addr_w[i]), int'(mon_e.addr));
                            else if (wdata[i] !== mon_e.val[i])
                                report("write_data", i, int'($signed(wdata[i])),
                                       int'($signed(mon_e.val[i])));
                            if (mon_e.acc_cyc >= 0) begin
                                n_vec++;
                                if (cyc != mon_e.acc_cyc + ((i == 0) ? 2 : 1))
                                    report("latency", i, cyc - mon_e.acc_cyc, (i == 0) ? 2 : 1);
                            end
                        end
                    end
                end
            end
        end
        if (fin) begin
            for (int i = 0; i < NI; i++) begin
                n_vec++;
                if (rdp[i] != expq.size()) report("pending_writes", i, rdp[i], expq.size());
            end
            n_vec++;
            if (stim_tmo) report("clear_timeout", 0, 1, 0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1);
    end

    // Stimulus
    initial begin
        int sv [NI];
        rst = 1'b1;
        chk_busy = 1'b0;
        fin = 1'b0;
        stim_tmo = 1'b0;
        for (int i = 0; i < NI; i++) begin
            rdp[i] = 0;
            for (int k = 0; k < N; k++) model[i][k] = 0;
        end
        set_in(0, 0, 0, 0, 0);
        repeat (3) tick;

        // Release reset and accept in the very first cycle.
        rst = 1'b0;
        set_in(1, 3, 5, 1, 0);
        tick; set_in(1, 3, 7, 0, 0);
        tick; set_in(0, 0, 0, 0, 0);

        // Back-to-back accumulates to one address.
        tick; set_in(1, 2, 10, 1, 0);
        for (int k = 0; k < 4; k++) begin tick; set_in(1, 2, 1, 0, 0); end
        tick; set_in(0, 0, 0, 0, 0);

        // Interleaved addresses.
        for (int k = 0; k < 4; k++) begin tick; set_in(1, (k % 2) + 1, 1, 1, 0); end
        for (int k = 0; k < 4; k++) begin tick; set_in(1, (k % 2) + 1, 1, 0, 0); end
        tick; set_in(0, 0, 0, 0, 0);

        // Overflow at both ends of the signed range.
        tick; set_in(1, 5, 120, 1, 0);
        tick; set_in(1, 5, 10, 0, 0);
        tick; set_in(1, 6, -120, 1, 0);
        tick; set_in(1, 6, -10, 0, 0);
        tick; set_in(0, 0, 0, 0, 0);

        // Randomised traffic, biased towards a few hot addresses.
        for (int k = 0; k < 400; k++) begin
            tick;
            set_in($urandom_range(0, 3) != 0,
                   ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15),
                   int'($urandom_range(0, 255)) - 128,
                   $urandom_range(0, 7) == 0, 0);
        end

        // Clear with operations in flight; psum offered alongside is refused.
        tick; set_in(1, 4, 3, 0, 0);
        tick; set_in(1, 5, 3, 0, 0);
        tick; set_in(1, 7, 9, 0, 1);
        tick; set_in(0, 0, 0, 0, 0); chk_busy = 1'b1;
        tick; chk_busy = 1'b0;
        for (int k = 0; k < 60 && !(in_ready[0] && in_ready[1]); k++) tick;
        if (!(in_ready[0] && in_ready[1])) stim_tmo = 1'b1;

        // Memory reads back zero after the sweep.
        tick; set_in(1, 0, 17, 0, 0);
        tick; set_in(1, 4, -33, 0, 0);
        tick; set_in(1, 5, 64, 0, 0);
        tick; set_in(1, 15, -1, 0, 0);
        tick; set_in(0, 0, 0, 0, 0);
        repeat (2) tick;

        // Reset one cycle after an accept: the write is dropped.
        for (int i = 0; i < NI; i++) sv[i] = model[i][9];
        set_in(1, 9, 3, 0, 0);
        tick;
        set_in(0, 0, 0, 0, 0);
        rst = 1'b1;
        for (int i = 0; i < NI; i++) model[i][9] = sv[i];
        repeat (2) tick;
        rst = 1'b0;
        set_in(1, 9, 4, 0, 0);
        tick; set_in(0, 0, 0, 0, 0);

        repeat (6) tick;
        fin = 1'b1;
    end

endmodule
